meteor_spawn_scheduler: RTL and testbench

//  Sequences meteor spawning during gameplay. Paces spawns off the frame tick and allocates a free meteor slot

---
 rtl/meteor_pkg.sv | 10 +
 rtl/meteor_lfsr.sv | 18 +
 rtl/meteor_spawn_scheduler.sv | 146 ++++++++++++++
 tb/tb_meteor_spawn_scheduler.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/meteor_pkg.sv
// Constants and types shared by the meteor spawn scheduler and the meteor object array.
package meteor_pkg;

  typedef enum logic [1:0] {IDLE, COUNT, SEARCH, ISSUE} sched_state_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam int unsigned SCREEN_W  = 640;
  localparam int unsigned METEOR_W  = 32;

endpackage

// File: rtl/meteor_lfsr.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11), free-running out of reset; also used for speed randomisation.
module meteor_lfsr
  import meteor_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset_n,
  output logic [15:0] lfsr
);

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      lfsr <= LFSR_SEED;
    end else begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
  end

endmodule

// File: rtl/meteor_spawn_scheduler.sv
// Paces meteor spawns off the frame tick and hands a round-robin free slot to the meteor array.
// Define METEOR_RAMP_EN to shorten the spawn interval and raise the level as spawns accumulate.
module meteor_spawn_scheduler
  import meteor_pkg::*;
#(
  parameter int unsigned NUM_METEORS      = 8,
  parameter int unsigned BASE_INTERVAL    = 60,
  parameter int unsigned MIN_INTERVAL     = 15,
  parameter int unsigned RAMP_STEP        = 5,
  parameter int unsigned SPAWNS_PER_LEVEL = 10,
  parameter int unsigned X_LIMIT          = SCREEN_W - METEOR_W,
  localparam int unsigned SW              = $clog2(NUM_METEORS)
) (
  input  logic                   Clk,
  input  logic                   Reset_n,
  input  logic                   frame_tick,
  input  logic                   game_screen,
  input  logic [NUM_METEORS-1:0] meteor_active,
  input  logic                   spawn_ready,
  output logic                   spawn_valid,
  output logic [SW-1:0]          spawn_slot,
  output logic [9:0]             spawn_x,
  output logic [3:0]             level,
  output logic [7:0]             skip_count
);

  // Folding r-512 into range only works when X_LIMIT is at least 512.
  if (BASE_INTERVAL < 1 || BASE_INTERVAL > 255 || MIN_INTERVAL < 1 ||
      MIN_INTERVAL > BASE_INTERVAL || RAMP_STEP > 255 || SPAWNS_PER_LEVEL < 1 ||
      SPAWNS_PER_LEVEL > 256 || X_LIMIT < 512 || X_LIMIT > 1024) begin : g_bad_cfg
    $error("meteor_spawn_scheduler: illegal parameter set");
  end

  sched_state_t state;
  logic [7:0]    cnt;
  logic [7:0]    interval;
  logic [SW-1:0] rr_ptr;
  logic [15:0]   lfsr;
  logic [9:0]    rnd;
  logic [9:0]    x_next;
  logic [SW:0]   free;
  logic [SW-1:0] rr_next;
  logic          unused_lfsr;

  meteor_lfsr u_lfsr (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .lfsr    (lfsr)
  );

  // Lowest offset from start wins; returns {found, slot}.
  function automatic logic [SW:0] find_free(input logic [NUM_METEORS-1:0] busy,
                                            input logic [SW-1:0] start);
    logic [SW:0]   res;
    logic [SW-1:0] sel;
    res = '0;
    for (int i = NUM_METEORS - 1; i >= 0; i--) begin
      sel = SW'((int'(start) + i) % int'(NUM_METEORS));
      if (!busy[sel]) res = {1'b1, sel};
    end
    return res;
  endfunction

  assign rnd         = lfsr[9:0];
  assign x_next      = (rnd < 10'(X_LIMIT)) ? rnd : rnd - 10'd512;
  assign free        = find_free(meteor_active, rr_ptr);
  assign rr_next     = (spawn_slot == SW'(NUM_METEORS - 1)) ? '0 : spawn_slot + 1'b1;
  assign unused_lfsr = ^lfsr[15:10];

`ifdef METEOR_RAMP_EN
  logic [7:0] spawns;
`else
  assign interval = 8'(BASE_INTERVAL);
  assign level    = 4'd0;
`endif

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state       <= IDLE;
      spawn_valid <= 1'b0;
      spawn_slot  <= '0;
      spawn_x     <= '0;
      skip_count  <= '0;
      rr_ptr      <= '0;
      cnt         <= 8'(BASE_INTERVAL);
`ifdef METEOR_RAMP_EN
      interval    <= 8'(BASE_INTERVAL);
      level       <= '0;
      spawns      <= '0;
`endif
    end else if (!game_screen) begin
      state       <= IDLE;
      spawn_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          state      <= COUNT;
          cnt        <= interval;
          skip_count <= '0;
`ifdef METEOR_RAMP_EN
          level      <= '0;
          spawns     <= '0;
`endif
        end
        COUNT: begin
          if (frame_tick) begin
            if (cnt <= 8'd1) state <= SEARCH;
            else             cnt   <= cnt - 8'd1;
          end
        end
        SEARCH: begin
          if (free[SW]) begin
            spawn_slot  <= free[SW-1:0];
            spawn_x     <= x_next;
            spawn_valid <= 1'b1;
            state       <= ISSUE;
          end else begin
            if (skip_count != 8'hFF) skip_count <= skip_count + 8'd1;
            cnt   <= interval;
            state <= COUNT;
          end
        end
        ISSUE: begin
          if (spawn_ready) begin
            spawn_valid <= 1'b0;
            rr_ptr      <= rr_next;
            cnt         <= interval;
            state       <= COUNT;
`ifdef METEOR_RAMP_EN
            if (spawns == 8'(SPAWNS_PER_LEVEL - 1)) begin
              spawns <= '0;
              if (level != 4'hF) level <= level + 4'd1;
              interval <= ({1'b0, interval} >= 9'(MIN_INTERVAL + RAMP_STEP)) ?
                          interval - 8'(RAMP_STEP) : 8'(MIN_INTERVAL);
            end else begin
              spawns <= spawns + 8'd1;
            end
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_meteor_spawn_scheduler.sv
// Directed bench for meteor_spawn_scheduler in its default build (fixed 60-frame interval).
module tb_meteor_spawn_scheduler;

  logic       Clk = 1'b0;
  logic       Reset_n;
  logic       frame_tick;
  logic       game_screen;
  logic [7:0] meteor_active;
  logic       spawn_ready;
  logic       spawn_valid;
  logic [2:0] spawn_slot;
  logic [9:0] spawn_x;
  logic [3:0] level;
  logic [7:0] skip_count;

  int checks   = 0;
  int failures = 0;

  logic [9:0] x_held;

  meteor_spawn_scheduler dut (
    .Clk           (Clk),
    .Reset_n       (Reset_n),
    .frame_tick    (frame_tick),
    .game_screen   (game_screen),
    .meteor_active (meteor_active),
    .spawn_ready   (spawn_ready),
    .spawn_valid   (spawn_valid),
    .spawn_slot    (spawn_slot),
    .spawn_x       (spawn_x),
    .level         (level),
    .skip_count    (skip_count)
  );

  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // One frame: tick pulse for a cycle, then a quiet cycle.
  task automatic do_ticks(input int n);
    for (int k = 0; k < n; k++) begin
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      step();
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    Reset_n       = 1'b0;
    frame_tick    = 1'b0;
    game_screen   = 1'b1;
    meteor_active = 8'h00;
    spawn_ready   = 1'b0;

    // Reset held 3 cycles with game_screen high
    step(); step(); step();
    check("rst_valid", spawn_valid, 0);
    check("rst_slot",  spawn_slot,  0);
    check("rst_x",     spawn_x,     0);
    check("rst_level", level,       0);
    check("rst_skip",  skip_count,  0);

    // First spawn 60 ticks after release, plus SEARCH and ISSUE cycles
    Reset_n = 1'b1;
    step();
    do_ticks(59);
    check("t59_valid", spawn_valid, 0);
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    check("search_valid", spawn_valid, 0);
    step();
    check("first_valid", spawn_valid, 1);
    check("first_slot",  spawn_slot,  0);
    check("first_x_rng", spawn_x < 10'd608, 1);
    x_held = spawn_x;

    // Hold-off: ready low for 20 cycles
    for (int c = 0; c < 20; c++) step();
    check("hold_valid", spawn_valid, 1);
    check("hold_slot",  spawn_slot,  0);
    check("hold_x",     spawn_x,     x_held);
    spawn_ready = 1'b1;
    step();
    check("accept_drop", spawn_valid, 0);
    for (int c = 0; c < 5; c++) step();
    check("single_accept", spawn_valid, 0);

    // Round-robin: ptr=1, slots 0..2 busy -> 3; then 0..3 busy -> 4
    meteor_active = 8'b0000_0111;
    do_ticks(60);
    check("rr1_valid", spawn_valid, 1);
    check("rr1_slot",  spawn_slot,  3);
    check("rr1_x_rng", spawn_x < 10'd608, 1);
    step();
    check("rr1_drop", spawn_valid, 0);
    meteor_active = 8'b0000_1111;
    do_ticks(60);
    check("rr2_valid", spawn_valid, 1);
    check("rr2_slot",  spawn_slot,  4);
    step();
    check("rr2_drop", spawn_valid, 0);

    // All slots full on two attempts
    meteor_active = 8'hFF;
    do_ticks(60);
    check("full1_valid", spawn_valid, 0);
    check("full1_skip",  skip_count,  1);
    do_ticks(60);
    check("full2_valid", spawn_valid, 0);
    check("full2_skip",  skip_count,  2);
    // Counter reloaded to 60 after the skip
    meteor_active = 8'h00;
    do_ticks(59);
    check("reload_t59", spawn_valid, 0);
    do_ticks(1);
    check("reload_valid", spawn_valid, 1);
    check("reload_slot",  spawn_slot,  5);
    step();
    check("reload_drop", spawn_valid, 0);

    // game_screen falls during ISSUE
    spawn_ready = 1'b0;
    do_ticks(60);
    check("abort_pre", spawn_valid, 1);
    check("abort_slot", spawn_slot, 6);
    game_screen = 1'b0;
    step();
    check("abort_valid", spawn_valid, 0);
    check("abort_skip_kept", skip_count, 2);
    do_ticks(70);
    check("idle_no_spawn", spawn_valid, 0);
    game_screen = 1'b1;
    step();
    check("reentry_skip",  skip_count, 0);
    check("reentry_level", level,      0);
    // Abandoned command did not advance rr_ptr
    do_ticks(60);
    check("reentry_valid", spawn_valid, 1);
    check("reentry_slot",  spawn_slot,  6);

    // Reset mid-handshake
    Reset_n = 1'b0;
    step();
    check("midrst_valid", spawn_valid, 0);
    check("midrst_slot",  spawn_slot,  0);
    check("midrst_x",     spawn_x,     0);
    Reset_n = 1'b1;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
